bmem_arbiter: RTL

Two-requester arbiter and burst sequencer sharing the single 64-bit burst memory port between the instruction cache and data cache. Accepts 256-bit cacheline read/write requests on each cache's DFP port, grants one at a time round-robin, issues the bmem command, splits writes into four 64-bit beats and assembles four read beats into a line. It sits between both caches and bmem, replacing any per-cache serializer.

---
 rtl/bmem_arbiter_if.sv | 88 ++++++++
 rtl/bmem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bmem_arbiter_if
//  Description : Bundles the two cache DFP ports and the shared 64-bit burst
//                memory port served by bmem_arbiter.
//
//                Signal groups:
//                  i_dfp_*  I-cache line request/response (read only)
//                  d_dfp_*  D-cache line request/response (read + writeback)
//                  bmem_*   shared burst memory command/beat port
//
//                Modports:
//                  slave  : the arbiter's view. It serves the cache requests
//                           and drives the bmem command side.
//                  master : the environment's view. It holds both caches and
//                           the burst memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bmem_arbiter_if;

    // I-cache DFP
    logic [31:0]  i_dfp_addr;
    logic         i_dfp_read;
    logic [255:0] i_dfp_rdata;
    logic         i_dfp_resp;

    // D-cache DFP
    logic [31:0]  d_dfp_addr;
    logic         d_dfp_read;
    logic         d_dfp_write;
    logic [255:0] d_dfp_wdata;
    logic [255:0] d_dfp_rdata;
    logic         d_dfp_resp;

    // Burst memory port
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    modport slave (
        input  i_dfp_addr,
        input  i_dfp_read,
        output i_dfp_rdata,
        output i_dfp_resp,
        input  d_dfp_addr,
        input  d_dfp_read,
        input  d_dfp_write,
        input  d_dfp_wdata,
        output d_dfp_rdata,
        output d_dfp_resp,
        output bmem_addr,
        output bmem_read,
        output bmem_write,
        output bmem_wdata,
        input  bmem_ready,
        input  bmem_raddr,
        input  bmem_rdata,
        input  bmem_rvalid
    );

    modport master (
        output i_dfp_addr,
        output i_dfp_read,
        input  i_dfp_rdata,
        input  i_dfp_resp,
        output d_dfp_addr,
        output d_dfp_read,
        output d_dfp_write,
        output d_dfp_wdata,
        input  d_dfp_rdata,
        input  d_dfp_resp,
        input  bmem_addr,
        input  bmem_read,
        input  bmem_write,
        input  bmem_wdata,
        output bmem_ready,
        output bmem_raddr,
        output bmem_rdata,
        output bmem_rvalid
    );

endinterface
`default_nettype wire

// File: rtl/bmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bmem_arbiter
//  Description : Round-robin arbiter and burst sequencer that shares one
//                64-bit burst memory port between the I-cache and D-cache.
//                A granted 256-bit line request becomes one bmem command.
//                Writes are split into four 64-bit beats. Reads collect four
//                address-tagged beats back into a line.
//
//  Ports       :
//    clk   in   system clock, all state on the rising edge
//    rst   in   asynchronous active-high reset
//    bus   slave modport of bmem_arbiter_if
//            i_dfp_addr/read  -> i_dfp_rdata/resp   (I-cache line reads)
//            d_dfp_addr/read/write/wdata -> d_dfp_rdata/resp (D-cache)
//            bmem_addr/read/write/wdata  -> memory command and write beats
//            bmem_ready/raddr/rdata/rvalid <- memory acceptance and read beats
//  Revision    : 1.0 - initial release
// ============================================================================
module bmem_arbiter (
    input  wire logic        clk,
    input  wire logic        rst,
    bmem_arbiter_if.slave    bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_LAST_BEAT = 2'd3;

    // ------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR      = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    // ------------------------------------------------------------------
    // Registered transaction context
    // ------------------------------------------------------------------
    logic           r_grant_d;       // 1: current transaction belongs to D
    logic           r_last_grant_d;  // 1: most recent grant went to D
    logic [31:0]    r_addr;          // latched line address, low 5 bits zero
    logic [1:0]     r_rcount;        // read beats stored so far
    logic [1:0]     r_wcount;        // write beats accepted so far
    logic [191:0]   r_line;          // first three read beats of the line
    logic [255:0]   r_i_rdata;       // last completed I-cache line
    logic [255:0]   r_d_rdata;       // last completed D-cache line

    // ------------------------------------------------------------------
    // Request decode and arbitration
    // ------------------------------------------------------------------
    logic           w_i_req;
    logic           w_d_req;
    logic           w_any_req;
    logic           w_pick_d;
    logic           w_pick_write;
    logic [31:0]    w_sel_addr;
    logic [31:0]    w_sel_line_addr;
    logic           w_beat_ok;
    logic           w_rd_last;
    logic           w_wr_last;

    assign w_i_req   = bus.i_dfp_read;
    assign w_d_req   = bus.d_dfp_read | bus.d_dfp_write;
    assign w_any_req = w_i_req | w_d_req;

    // D wins when it is alone, or when both request and I was granted last.
    // After reset last_grant points at D, so the first tie goes to I.
    assign w_pick_d = w_d_req & (~w_i_req | ~r_last_grant_d);

    // A D-cache read and writeback asserted together resolve to the write.
    assign w_pick_write = w_pick_d & bus.d_dfp_write;

    assign w_sel_addr      = w_pick_d ? bus.d_dfp_addr : bus.i_dfp_addr;
    assign w_sel_line_addr = {w_sel_addr[31:5], 5'b0};

    // Only beats tagged with our own line address count; anything else on
    // the return path belongs to someone else and is dropped.
    assign w_beat_ok = bus.bmem_rvalid && (bus.bmem_raddr == r_addr);
    assign w_rd_last = (r_state == S_RD_DATA) && w_beat_ok
                       && (r_rcount == c_LAST_BEAT);
    assign w_wr_last = (r_state == S_WR) && bus.bmem_ready
                       && (r_wcount == c_LAST_BEAT);

    // Offset bits of the request addresses are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{bus.i_dfp_addr[4:0], bus.d_dfp_addr[4:0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and memory-side / response outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        bus.bmem_read   = 1'b0;
        bus.bmem_write  = 1'b0;
        bus.bmem_addr   = 32'd0;
        bus.bmem_wdata  = 64'd0;
        bus.i_dfp_resp  = 1'b0;
        bus.d_dfp_resp  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = w_pick_write ? S_WR : S_RD_REQ;
                end
            end

            S_RD_REQ: begin
                // Command held until the memory accepts it.
                bus.bmem_read = 1'b1;
                bus.bmem_addr = r_addr;
                if (bus.bmem_ready) begin
                    w_state_nxt = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                if (w_rd_last) begin
                    w_state_nxt = S_RESP;
                end
            end

            S_WR: begin
                // Beat r_wcount is presented until accepted.
                bus.bmem_write = 1'b1;
                bus.bmem_addr  = r_addr;
                bus.bmem_wdata = bus.d_dfp_wdata[{r_wcount, 6'd0} +: 64];
                if (w_wr_last) begin
                    w_state_nxt = S_RESP;
                end
            end

            S_RESP: begin
                // Single-cycle completion pulse. Requests are not sampled
                // here, so a held request is re-arbitrated in the next IDLE.
                bus.i_dfp_resp = ~r_grant_d;
                bus.d_dfp_resp = r_grant_d;
                w_state_nxt    = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction context, beat counters and line assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_d      <= 1'b0;
            r_last_grant_d <= 1'b1;
            r_addr         <= 32'd0;
            r_rcount       <= 2'd0;
            r_wcount       <= 2'd0;
            r_line         <= 192'd0;
            r_i_rdata      <= 256'd0;
            r_d_rdata      <= 256'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_d      <= w_pick_d;
                        r_last_grant_d <= w_pick_d;
                        r_addr         <= w_sel_line_addr;
                        r_rcount       <= 2'd0;
                        r_wcount       <= 2'd0;
                    end
                end

                S_RD_REQ: begin
                    if (bus.bmem_ready) begin
                        r_rcount <= 2'd0;
                    end
                end

                S_RD_DATA: begin
                    if (w_beat_ok) begin
                        // Counter wraps 3 -> 0 on the final beat.
                        r_rcount <= r_rcount + 2'd1;
                        if (r_rcount == c_LAST_BEAT) begin
                            // Final beat bypasses r_line straight into the
                            // requester's line register.
                            if (r_grant_d) begin
                                r_d_rdata <= {bus.bmem_rdata, r_line};
                            end else begin
                                r_i_rdata <= {bus.bmem_rdata, r_line};
                            end
                        end else begin
                            r_line[{r_rcount, 6'd0} +: 64] <= bus.bmem_rdata;
                        end
                    end
                end

                S_WR: begin
                    if (bus.bmem_ready) begin
                        r_wcount <= r_wcount + 2'd1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign bus.i_dfp_rdata = r_i_rdata;
    assign bus.d_dfp_rdata = r_d_rdata;

endmodule
`default_nettype wire
